// File: rtl/svc_rv_sram_arb.sv
// Arbitrates one single-port, 1-cycle-latency SRAM between the instruction-fetch
// and data ports of a RISC-V core: data wins, with a starvation limit for fetch.
module svc_rv_sram_arb #(
   parameter int SRAM_AW    = 10,
   parameter int XLEN       = 32,
   parameter int FAIR_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                i_req_valid,
   output logic                i_req_ready,
   input  logic [XLEN-1:0]     i_req_addr,
   output logic                i_rsp_valid,
   output logic [XLEN-1:0]     i_rsp_data,

   input  logic                d_req_valid,
   output logic                d_req_ready,
   input  logic [XLEN-1:0]     d_req_addr,
   input  logic                d_req_wen,
   input  logic [XLEN-1:0]     d_req_wdata,
   input  logic [XLEN/8-1:0]   d_req_wstrb,
   output logic                d_rsp_valid,
   output logic [XLEN-1:0]     d_rsp_data,

   output logic                sram_en,
   output logic [XLEN/8-1:0]   sram_wen,
   output logic [SRAM_AW-1:0]  sram_addr,
   output logic [XLEN-1:0]     sram_wdata,
   input  logic [XLEN-1:0]     sram_rdata
);

   localparam logic [1:0] RSP_NONE  = 2'd0;
   localparam logic [1:0] RSP_INSTR = 2'd1;
   localparam logic [1:0] RSP_DATA  = 2'd2;

   localparam logic [3:0] LIMIT = 4'(FAIR_LIMIT);

   logic [3:0] starve;
   logic [1:0] rsp_sel;
   logic [1:0] rsp_sel_next;
   logic       force_i;
   logic       d_grant;
   logic       i_grant;

   // Grant is purely combinational so ready is visible in the same cycle as valid.
   assign force_i     = i_req_valid && (starve == LIMIT);
   assign d_grant     = d_req_valid && !force_i;
   assign i_grant     = i_req_valid && (!d_req_valid || force_i);
   assign d_req_ready = d_grant;
   assign i_req_ready = i_grant;
   assign sram_wdata  = d_req_wdata;

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      sram_en      = 1'b0;
      sram_wen     = '0;
      sram_addr    = d_req_addr[SRAM_AW+1:2];
      rsp_sel_next = RSP_NONE;
      if (d_grant) begin
         sram_en      = 1'b1;
         sram_wen     = d_req_wen ? d_req_wstrb : '0;
         rsp_sel_next = d_req_wen ? RSP_NONE : RSP_DATA;
      end else if (i_grant) begin
         sram_en      = 1'b1;
         sram_addr    = i_req_addr[SRAM_AW+1:2];
         rsp_sel_next = RSP_INSTR;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve  <= 4'd0;
         rsp_sel <= RSP_NONE;
      end else begin
         rsp_sel <= rsp_sel_next;
         if (i_grant || !i_req_valid)
            starve <= 4'd0;
         else if (d_grant && starve != LIMIT)
            starve <= starve + 4'd1;
      end
   end

   // Read data is a passthrough; the registered tag says who it belongs to.
   assign i_rsp_valid = (rsp_sel == RSP_INSTR);
   assign d_rsp_valid = (rsp_sel == RSP_DATA);
   assign i_rsp_data  = sram_rdata;
   assign d_rsp_data  = sram_rdata;

endmodule

// File: tb/tb_svc_rv_sram_arb.sv
// Directed bench for svc_rv_sram_arb with a behavioural 1-cycle-latency SRAM
// model; preloads words through the data port, then walks the arbitration cases.
module tb_svc_rv_sram_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req_valid, i_req_ready, i_rsp_valid;
   logic [31:0] i_req_addr, i_rsp_data;
   logic        d_req_valid, d_req_ready, d_req_wen, d_rsp_valid;
   logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
   logic [3:0]  d_req_wstrb;
   logic        sram_en;
   logic [3:0]  sram_wen;
   logic [9:0]  sram_addr;
   logic [31:0] sram_wdata, sram_rdata;

   logic [31:0] mem [0:1023];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   svc_rv_sram_arb #(.SRAM_AW(10), .XLEN(32), .FAIR_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
      .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
      .d_req_wen(d_req_wen), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
      .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
      .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   // SRAM model: byte-masked write, or read data registered for the next cycle.
   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_wen == 4'b0000)
            sram_rdata <= mem[sram_addr];
         for (int b = 0; b < 4; b++)
            if (sram_wen[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic drive(input logic iv, input logic [31:0] ia, input logic dv,
                        input logic [31:0] da, input logic dw, input logic [31:0] wd,
                        input logic [3:0] ws);
      i_req_valid = iv;
      i_req_addr  = ia;
      d_req_valid = dv;
      d_req_addr  = da;
      d_req_wen   = dw;
      d_req_wdata = wd;
      d_req_wstrb = ws;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 4'h0);
      #2;
      check("reset_i_rsp_valid", i_rsp_valid, 1'b0);
      check("reset_d_rsp_valid", d_rsp_valid, 1'b0);
      check("reset_sram_en_idle", sram_en, 1'b0);
      tick();
      tick();
      rst = 1'b0;

      // Preload word 2 and clear word 4 through the data port.
      drive(0, 0, 1, 32'h8, 1, 32'h0013_0313, 4'hf);
      #1;
      check("preload_d_ready", d_req_ready, 1'b1);
      check("preload_sram_wen", sram_wen, 4'hf);
      check("preload_sram_addr", sram_addr, 10'd2);
      tick();
      check("preload_no_d_rsp", d_rsp_valid, 1'b0);
      drive(0, 0, 1, 32'h10, 1, 32'h0, 4'hf);
      tick();

      // Instruction only.
      drive(1, 32'h8, 0, 0, 0, 0, 4'h0);
      #1;
      check("ionly_i_ready", i_req_ready, 1'b1);
      check("ionly_sram_en", sram_en, 1'b1);
      check("ionly_sram_addr", sram_addr, 10'd2);
      check("ionly_sram_wen", sram_wen, 4'h0);
      tick();
      check("ionly_i_rsp_valid", i_rsp_valid, 1'b1);
      check("ionly_i_rsp_data", i_rsp_data, 32'h0013_0313);
      check("ionly_d_rsp_valid", d_rsp_valid, 1'b0);

      // Partial write then read back.
      drive(0, 0, 1, 32'h10, 1, 32'hDEAD_BEEF, 4'b0011);
      #1;
      check("wr_d_ready", d_req_ready, 1'b1);
      check("wr_i_ready", i_req_ready, 1'b0);
      check("wr_sram_wen", sram_wen, 4'b0011);
      check("wr_sram_addr", sram_addr, 10'd4);
      check("wr_sram_wdata", sram_wdata, 32'hDEAD_BEEF);
      tick();
      check("wr_no_d_rsp", d_rsp_valid, 1'b0);
      check("wr_no_i_rsp", i_rsp_valid, 1'b0);
      drive(0, 0, 1, 32'h10, 0, 0, 4'h0);
      #1;
      check("rd_sram_wen", sram_wen, 4'h0);
      tick();
      check("rd_d_rsp_valid", d_rsp_valid, 1'b1);
      check("rd_d_rsp_data", d_rsp_data, 32'h0000_BEEF);

      // Address wrap and misalignment.
      drive(0, 0, 1, 32'h0000_1004, 0, 0, 4'h0);
      #1;
      check("wrap_sram_addr", sram_addr, 10'd1);
      check("wrap_sram_en", sram_en, 1'b1);
      tick();
      drive(1, 32'h0000_0007, 0, 0, 0, 0, 4'h0);
      #1;
      check("misalign_sram_addr", sram_addr, 10'd1);
      tick();

      // Contention: four data grants, one forced fetch, then data again.
      for (int k = 0; k < 6; k++) begin
         drive(1, 32'h8, 1, 32'h10, 0, 0, 4'h0);
         #1;
         check($sformatf("cont%0d_d_ready", k), d_req_ready, (k == 4) ? 1'b0 : 1'b1);
         check($sformatf("cont%0d_i_ready", k), i_req_ready, (k == 4) ? 1'b1 : 1'b0);
         check($sformatf("cont%0d_sram_addr", k), sram_addr, (k == 4) ? 10'd2 : 10'd4);
         tick();
      end

      // Back-to-back mixed: I-read, D-read, D-write, I-read.
      drive(1, 32'h8, 0, 0, 0, 0, 4'h0);
      tick();
      check("b2b0_i_rsp_valid", i_rsp_valid, 1'b1);
      check("b2b0_d_rsp_valid", d_rsp_valid, 1'b0);
      check("b2b0_i_rsp_data", i_rsp_data, 32'h0013_0313);
      drive(0, 0, 1, 32'h10, 0, 0, 4'h0);
      tick();
      check("b2b1_i_rsp_valid", i_rsp_valid, 1'b0);
      check("b2b1_d_rsp_valid", d_rsp_valid, 1'b1);
      check("b2b1_d_rsp_data", d_rsp_data, 32'h0000_BEEF);
      drive(0, 0, 1, 32'h20, 1, 32'h1234_5678, 4'hf);
      tick();
      check("b2b2_i_rsp_valid", i_rsp_valid, 1'b0);
      check("b2b2_d_rsp_valid", d_rsp_valid, 1'b0);
      drive(1, 32'h8, 0, 0, 0, 0, 4'h0);
      tick();
      check("b2b3_i_rsp_valid", i_rsp_valid, 1'b1);
      check("b2b3_d_rsp_valid", d_rsp_valid, 1'b0);

      // Build up some starvation, then reset in the middle of a fetch.
      drive(1, 32'h8, 1, 32'h20, 0, 0, 4'h0);
      tick();
      tick();
      check("pre_reset_starve", dut.starve, 4'd2);
      drive(1, 32'h8, 0, 0, 0, 0, 4'h0);
      #1;
      check("rst_mid_i_ready", i_req_ready, 1'b1);
      rst = 1'b1;
      #1;
      check("rst_mid_starve", dut.starve, 4'd0);
      check("rst_ready_ungated", i_req_ready, 1'b1);
      check("rst_sram_en_follows", sram_en, 1'b1);
      tick();
      check("rst_mid_i_rsp_valid", i_rsp_valid, 1'b0);
      drive(0, 0, 0, 0, 0, 0, 4'h0);
      rst = 1'b0;
      tick();
      drive(1, 32'h8, 0, 0, 0, 0, 4'h0);
      tick();
      check("post_rst_i_rsp_valid", i_rsp_valid, 1'b1);
      check("post_rst_i_rsp_data", i_rsp_data, 32'h0013_0313);
      drive(0, 0, 0, 0, 0, 0, 4'h0);
      tick();
      check("idle_i_rsp_valid", i_rsp_valid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
